// File: rtl/issue_queue_multi.sv
// In-order multi-issue instruction queue between decode and rename/dispatch.
// Issues the longest in-order prefix that the RS lanes and ROB/LB/SB credits accept.
module issue_queue_multi #(
  parameter int ENTRY_WIDTH      = 158,
  parameter int IQ_ADDR_WIDTH    = 4,
  parameter int ISSUE_WIDTH      = 2,
  parameter int EXECUTION_LANES  = 3,
  parameter int LANE_INDEX_WIDTH = 2,
  parameter int CREDIT_WIDTH     = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic                                   decode_valid,
  output logic                                   decode_ready,
  input  logic [ENTRY_WIDTH-1:0]                 decode_data,
  input  logic [EXECUTION_LANES-1:0]             RS_ready,
  input  logic [CREDIT_WIDTH-1:0]                ROB_free,
  input  logic [CREDIT_WIDTH-1:0]                LB_free,
  input  logic [CREDIT_WIDTH-1:0]                SB_free,
  output logic [ISSUE_WIDTH-1:0]                 issue_valid,
  output logic [ISSUE_WIDTH*ENTRY_WIDTH-1:0]     issue_data,
  output logic [ISSUE_WIDTH*LANE_INDEX_WIDTH-1:0] issue_lane,
  output logic [2:0]                             issue_count,
  output logic [IQ_ADDR_WIDTH:0]                 occupancy,
  output logic [31:0]                            stall_cycles
);

  localparam int DEPTH = 1 << IQ_ADDR_WIDTH;
  localparam int PW    = IQ_ADDR_WIDTH + 1;
  localparam int NL    = 1 << LANE_INDEX_WIDTH;
  localparam logic [2:0] OP_STORE = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;

  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic                   flush_last;
  logic [31:0]            stall_q;
  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic                   enq;
  logic                   stall_hit;

  logic [NL-1:0]               rs_ext;
  logic [NL-1:0]               lane_used;
  logic [CREDIT_WIDTH-1:0]     n_ld;
  logic [CREDIT_WIDTH-1:0]     n_st;
  logic [IQ_ADDR_WIDTH-1:0]    idx;
  logic [ENTRY_WIDTH-1:0]      ent;
  logic [LANE_INDEX_WIDTH-1:0] lane;
  logic [2:0]                  op;
  logic                        ok;

  assign occupancy    = tail - head;
  assign decode_ready = occupancy != PW'(DEPTH);
  assign enq          = decode_valid && decode_ready &&
                        !flush && !flush_last;
  assign stall_cycles = stall_q;
  assign stall_hit    = (occupancy != '0) &&
                        (issue_count == 3'd0) && !flush;

  // ok carries the prefix: once a slot fails, no later slot may issue
  always_comb begin
    rs_ext      = '0;
    rs_ext[EXECUTION_LANES-1:0] = RS_ready;
    lane_used   = '0;
    n_ld        = '0;
    n_st        = '0;
    idx         = '0;
    ent         = '0;
    lane        = '0;
    op          = '0;
    ok          = !flush;
    issue_valid = '0;
    issue_data  = '0;
    issue_lane  = '0;
    issue_count = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      idx  = head[IQ_ADDR_WIDTH-1:0] + IQ_ADDR_WIDTH'(k);
      ent  = mem[idx];
      lane = ent[LANE_INDEX_WIDTH:1];
      op   = ent[LANE_INDEX_WIDTH+3:LANE_INDEX_WIDTH+1];
      n_ld = n_ld + CREDIT_WIDTH'(op == OP_LOAD);
      n_st = n_st + CREDIT_WIDTH'(op == OP_STORE);
      ok   = ok &&
             (PW'(k) < occupancy) &&
             rs_ext[lane] &&
             !lane_used[lane] &&
             (CREDIT_WIDTH'(k + 1) <= ROB_free) &&
             (n_ld <= LB_free) &&
             (n_st <= SB_free);
      issue_valid[k] = ok;
      issue_data[k*ENTRY_WIDTH +: ENTRY_WIDTH] = ent;
      issue_lane[k*LANE_INDEX_WIDTH +: LANE_INDEX_WIDTH] = lane;
      if (ok) begin
        lane_used[lane] = 1'b1;
        issue_count     = issue_count + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      flush_last <= 1'b0;
      stall_q    <= '0;
    end else begin
      flush_last <= flush;
      if (flush) head <= tail;
      else       head <= head + PW'(issue_count);
      if (enq)   tail <= tail + PW'(1);
      if (stall_hit && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (enq) mem[tail[IQ_ADDR_WIDTH-1:0]] <= decode_data;
  end

endmodule

// File: tb/tb_issue_queue_multi.sv
// Bench for issue_queue_multi: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_issue_queue_multi;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic         decode_valid;
  logic         decode_ready;
  logic [157:0] decode_data;
  logic [2:0]   RS_ready;
  logic [7:0]   ROB_free;
  logic [7:0]   LB_free;
  logic [7:0]   SB_free;
  logic [1:0]   issue_valid;
  logic [315:0] issue_data;
  logic [3:0]   issue_lane;
  logic [2:0]   issue_count;
  logic [4:0]   occupancy;
  logic [31:0]  stall_cycles;

  issue_queue_multi dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .decode_valid (decode_valid),
    .decode_ready (decode_ready),
    .decode_data  (decode_data),
    .RS_ready     (RS_ready),
    .ROB_free     (ROB_free),
    .LB_free      (LB_free),
    .SB_free      (SB_free),
    .issue_valid  (issue_valid),
    .issue_data   (issue_data),
    .issue_lane   (issue_lane),
    .issue_count  (issue_count),
    .occupancy    (occupancy),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  int           checks = 0;
  int           failures = 0;
  logic [157:0] q[$];
  bit           fl_last;
  longint       stall_m;
  int           exp_cnt;

  task automatic chk(input string nm, input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [157:0] mk(input int lane, input int op);
    logic [159:0] r;
    logic [157:0] e;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    e = r[157:0];
    e[2:1] = lane[1:0];
    e[5:3] = op[2:0];
    return e;
  endfunction

  task automatic setin(input bit v, input logic [157:0] d,
                       input logic [2:0] rs, input int rob,
                       input int lb, input int sb, input bit fl);
    decode_valid = v;
    decode_data  = d;
    RS_ready     = rs;
    ROB_free     = 8'(rob);
    LB_free      = 8'(lb);
    SB_free      = 8'(sb);
    flush        = fl;
  endtask

  // Model: issue count is the length of the longest acceptable prefix
  task automatic settle();
    int n, ld, st, ln, op;
    bit [3:0] used;
    logic [157:0] e;
    logic [1:0] ev;
    #1;
    n = 0; ld = 0; st = 0; used = '0;
    if (!flush) begin
      for (int k = 0; k < 2 && k < q.size(); k++) begin
        e  = q[k];
        ln = int'(e[2:1]);
        op = int'(e[5:3]);
        if (ln >= 3 || !RS_ready[ln] || used[ln]) break;
        if (op == 1) ld++;
        if (op == 0) st++;
        if (k + 1 > int'(ROB_free)) break;
        if (ld > int'(LB_free) || st > int'(SB_free)) break;
        used[ln] = 1'b1;
        n++;
      end
    end
    exp_cnt = n;
    ev = 2'((1 << n) - 1);
    chk("count", 160'(issue_count), 160'(n));
    chk("valid", 160'(issue_valid), 160'(ev));
    for (int k = 0; k < n; k++) begin
      e = q[k];
      chk("data", 160'(issue_data[k*158 +: 158]), 160'(e));
      chk("lane", 160'(issue_lane[k*2 +: 2]), 160'(e[2:1]));
    end
    chk("occ", 160'(occupancy), 160'(q.size()));
    chk("ready", 160'(decode_ready), 160'(q.size() != 16));
    chk("stall", 160'(stall_cycles), 160'(stall_m[31:0]));
  endtask

  task automatic adv();
    bit enq;
    @(posedge clock);
    enq = decode_valid && (q.size() != 16) && !flush && !fl_last;
    if (q.size() > 0 && exp_cnt == 0 && !flush && stall_m < 64'hFFFFFFFF)
      stall_m++;
    if (flush) q.delete();
    else repeat (exp_cnt) void'(q.pop_front());
    if (enq) q.push_back(decode_data);
    fl_last = flush;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q.delete();
    fl_last = 1'b0;
    stall_m = 0;
    #2;
    chk("rst_occ", 160'(occupancy), 160'(0));
    chk("rst_ready", 160'(decode_ready), 160'(1));
    chk("rst_valid", 160'(issue_valid), 160'(0));
    chk("rst_count", 160'(issue_count), 160'(0));
    chk("rst_stall", 160'(stall_cycles), 160'(0));
    @(negedge clock);
    reset = 1'b1;
  endtask

  logic [157:0] x3;

  initial begin
    setin(0, '0, 3'b000, 8, 8, 8, 0);
    do_reset();

    // lanes 0,1,2: first word alone, then 1 and 2 together
    setin(1, mk(0, 2), 3'b111, 8, 8, 8, 0);
    settle(); chk("t1_empty", 160'(issue_valid), 160'(2'b00)); adv();
    setin(1, mk(1, 2), 3'b001, 8, 8, 8, 0);
    settle(); chk("t1_first", 160'(issue_valid), 160'(2'b01)); adv();
    setin(1, mk(2, 2), 3'b001, 8, 8, 8, 0);
    settle(); adv();
    setin(0, '0, 3'b111, 8, 8, 8, 0);
    settle();
    chk("t1_pair", 160'(issue_valid), 160'(2'b11));
    chk("t1_lanes", 160'(issue_lane), 160'(4'b1001));
    adv();
    settle(); chk("t1_occ", 160'(occupancy), 160'(0)); adv();

    // same-lane pair issues one per cycle
    do_reset();
    setin(1, mk(1, 2), 3'b000, 8, 8, 8, 0); settle(); adv();
    setin(1, mk(1, 2), 3'b000, 8, 8, 8, 0); settle(); adv();
    setin(0, '0, 3'b111, 8, 8, 8, 0);
    settle(); chk("t2_v0", 160'(issue_valid), 160'(2'b01)); adv();
    settle(); chk("t2_v1", 160'(issue_valid), 160'(2'b01));
    chk("t2_stall", 160'(stall_cycles), 160'(1)); adv();

    // load-buffer and ROB credit limits
    do_reset();
    for (int i = 0; i < 3; i++) begin
      setin(1, mk(i, 1), 3'b000, 8, 8, 8, 0); settle(); adv();
    end
    setin(0, '0, 3'b111, 8, 1, 8, 0);
    settle(); chk("t3_lb", 160'(issue_count), 160'(1)); adv();
    setin(0, '0, 3'b111, 0, 8, 8, 0);
    settle(); chk("t3_rob", 160'(issue_count), 160'(0));
    chk("t3_st0", 160'(stall_cycles), 160'(2)); adv();
    settle(); chk("t3_st1", 160'(stall_cycles), 160'(3)); adv();

    // fill to full across pointer wrap, then drain in order
    do_reset();
    for (int i = 0; i < 20; i++) begin
      setin(1, mk(i % 3, 2), 3'b111, 8, 8, 8, 0); settle(); adv();
    end
    setin(0, '0, 3'b111, 8, 8, 8, 0); settle(); adv();
    for (int i = 0; i < 16; i++) begin
      setin(1, mk(i % 2, i % 8), 3'b000, 8, 8, 8, 0); settle(); adv();
    end
    setin(1, mk(0, 2), 3'b000, 8, 8, 8, 0);
    settle();
    chk("t4_full", 160'(decode_ready), 160'(0));
    chk("t4_occ", 160'(occupancy), 160'(16));
    adv();
    settle(); chk("t4_nowr", 160'(occupancy), 160'(16)); adv();
    for (int i = 0; i < 12; i++) begin
      setin(0, '0, 3'b111, 8, 8, 8, 0); settle(); adv();
    end
    settle(); chk("t4_empty", 160'(occupancy), 160'(0)); adv();

    // flush drops the in-flight word and the one after
    do_reset();
    for (int i = 0; i < 5; i++) begin
      setin(1, mk(0, 2), 3'b000, 8, 8, 8, 0); settle(); adv();
    end
    setin(1, mk(0, 2), 3'b000, 8, 8, 8, 1); settle(); adv();
    setin(1, mk(0, 2), 3'b000, 8, 8, 8, 0);
    settle(); chk("t5_occ0", 160'(occupancy), 160'(0)); adv();
    x3 = mk(0, 2);
    setin(1, x3, 3'b000, 8, 8, 8, 0);
    settle(); chk("t5_occ1", 160'(occupancy), 160'(0)); adv();
    setin(0, '0, 3'b111, 8, 8, 8, 0);
    settle();
    chk("t5_occ2", 160'(occupancy), 160'(1));
    chk("t5_data", 160'(issue_data[157:0]), 160'(x3));
    adv();

    // asynchronous reset in the middle of a drain
    do_reset();
    for (int i = 0; i < 9; i++) begin
      setin(1, mk(i % 2, 2), 3'b000, 8, 8, 8, 0); settle(); adv();
    end
    setin(0, '0, 3'b111, 8, 8, 8, 0); settle(); adv();
    settle(); chk("t6_occ7", 160'(occupancy), 160'(7));
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      setin($urandom_range(0, 9) < 7,
            mk(($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2),
               $urandom_range(0, 7)),
            3'($urandom), $urandom_range(0, 4),
            $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom_range(0, 39) == 0);
      settle();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
